// File: rtl/dsp_mac_unit.sv
// Execute-stage DSP multiply/accumulate unit: 2-stage valid/ready pipeline with a persistent accumulator.
// Supports signed MUL, MAC, dual-16-bit SIMD dot-product MAC and saturating MAC.
module dsp_mac_unit #(
  parameter int unsigned ACC_W  = 64,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dsp_mode,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_clr,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] res_hi,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned SW = ACC_W + 1;

  localparam logic signed [SW-1:0] SAT_MAX = SW'(signed'(32'h7FFF_FFFF));
  localparam logic signed [SW-1:0] SAT_MIN = SW'(signed'(32'h8000_0000));

  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_MAC  = 2'b01,
    MODE_SIMD = 2'b10,
    MODE_SAT  = 2'b11
  } mode_e;

  logic                    s1_valid_q;
  mode_e                   s1_mode_q;
  logic                    s1_clr_q;
  logic signed [ACC_W-1:0] s1_p_q;

  logic                    s2_valid_q, s2_valid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [W-1:0]            res_data_q, res_data_d;
  logic [W-1:0]            res_hi_q, res_hi_d;

  logic                    adv_c;
  logic signed [ACC_W-1:0] a_ext_c, b_ext_c, mul_c, simd_c, p_c;
  logic signed [W-1:0]     lo_prod_c, hi_prod_c;
  logic signed [ACC_W-1:0] base_c, wrap_c, sat_c;
  logic signed [SW-1:0]    sat_sum_c;

  // A stalled result register freezes the whole pipeline.
  assign adv_c    = !s2_valid_q | res_ready;
  assign op_ready = adv_c;

  // Stage-1 product: full 32x32 signed, or sum of two 16x16 signed halves.
  assign a_ext_c   = ACC_W'(signed'(op_a));
  assign b_ext_c   = ACC_W'(signed'(op_b));
  assign mul_c     = a_ext_c * b_ext_c;
  assign lo_prod_c = W'(signed'(op_a[HW-1:0])) * W'(signed'(op_b[HW-1:0]));
  assign hi_prod_c = W'(signed'(op_a[W-1:HW])) * W'(signed'(op_b[W-1:HW]));
  assign simd_c    = ACC_W'(lo_prod_c) + ACC_W'(hi_prod_c);
  assign p_c       = (dsp_mode == MODE_SIMD) ? simd_c : mul_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_MUL;
      s1_clr_q   <= 1'b0;
      s1_p_q     <= '0;
    end else if (adv_c) begin
      s1_valid_q <= op_valid;
      s1_mode_q  <= mode_e'(dsp_mode);
      s1_clr_q   <= op_clr;
      s1_p_q     <= p_c;
    end
  end

  // Stage-2 accumulate: wrapping sum plus a one-bit-wider sum for clamping.
  assign base_c    = s1_clr_q ? '0 : acc_q;
  assign wrap_c    = base_c + s1_p_q;
  assign sat_sum_c = SW'(base_c) + SW'(s1_p_q);

  always_comb begin
    sat_c = ACC_W'(sat_sum_c);
    if (sat_sum_c > SAT_MAX) begin
      sat_c = ACC_W'(SAT_MAX);
    end else if (sat_sum_c < SAT_MIN) begin
      sat_c = ACC_W'(SAT_MIN);
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_hi_d   = res_hi_q;
    if (adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (s1_mode_q)
          MODE_MUL: begin
            res_data_d = s1_p_q[W-1:0];
            res_hi_d   = '0;
          end
          MODE_SAT: begin
            if (SAT_EN) begin
              acc_d      = sat_c;
              res_data_d = sat_c[W-1:0];
              res_hi_d   = {W{sat_c[W-1]}};
            end else begin
              acc_d      = wrap_c;
              res_data_d = wrap_c[W-1:0];
              res_hi_d   = wrap_c[2*W-1:W];
            end
          end
          default: begin
            acc_d      = wrap_c;
            res_data_d = wrap_c[W-1:0];
            res_hi_d   = wrap_c[2*W-1:W];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_hi_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_hi_q   <= res_hi_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_data  = res_data_q;
  assign res_hi    = res_hi_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_dsp_mac_unit.sv
// Self-checking bench for dsp_mac_unit: directed ops, a behavioural accumulator model
// feeding a scoreboard queue, and a monitor that checks every consumed result.
module tb_dsp_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dsp_mode;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_clr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [31:0] res_hi;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] hi;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  longint      m_acc = 0;

  logic        stall_prev = 1'b0;
  logic [31:0] held_data  = '0;
  logic [31:0] held_hi    = '0;

  always #5 clk = ~clk;

  dsp_mac_unit #(.ACC_W(64), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dsp_mode  (dsp_mode),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_clr    (op_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_hi    (res_hi),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: computes the expected result of an op at its acceptance.
  task automatic model_push(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                            input logic clr);
    longint            p;
    longint            base;
    logic signed [64:0] s;
    exp_t              e;
    if (m == 2'b10)
      p = longint'(shortint'(a[15:0])) * longint'(shortint'(b[15:0]))
        + longint'(shortint'(a[31:16])) * longint'(shortint'(b[31:16]));
    else
      p = longint'(int'(a)) * longint'(int'(b));
    base = clr ? 64'sd0 : m_acc;
    case (m)
      2'b00: e = {p[31:0], 32'h0};
      2'b11: begin
        s = 65'(base) + 65'(p);
        if (s > 65'sh7FFF_FFFF)       m_acc = 64'sh7FFF_FFFF;
        else if (s < -65'sh8000_0000) m_acc = -64'sh8000_0000;
        else                          m_acc = 64'(s);
        e = {m_acc[31:0], {32{m_acc[31]}}};
      end
      default: begin
        m_acc = base + p;
        e = {m_acc[31:0], m_acc[63:32]};
      end
    endcase
    sb_q.push_back(e);
  endtask

  // Present one op and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic clr);
    bit done = 1'b0;
    dsp_mode = m;
    op_a     = a;
    op_b     = b;
    op_clr   = clr;
    op_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (op_ready) begin
        model_push(m, a, b, clr);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL send_timeout: op_ready observed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result is popped from the scoreboard; stalls must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        tests++;
        assert (sb_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_result: observed data %h with empty scoreboard, required none", res_data);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_hi", res_hi, e.hi);
        end
      end else if (res_valid) begin
        check("stall_op_ready", 32'(op_ready), 32'd0);
        if (stall_prev) begin
          check("stall_hold_data", res_data, held_data);
          check("stall_hold_hi", res_hi, held_hi);
        end
      end
      stall_prev <= res_valid & !res_ready;
      held_data  <= res_data;
      held_hi    <= res_hi;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation observed no $finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    dsp_mode  = 2'b00;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_clr    = 1'b0;
    res_ready = 1'b1;
    #12;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_hi", res_hi, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // MAC sequence with latency check on the first op
    send(2'b01, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    check("lat_after_1_edge", 32'(res_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("lat_after_2_edges", 32'(res_valid), 32'd1);
    send(2'b01, 32'd5, -32'sd6, 1'b0);
    send(2'b01, 32'd7, 32'd8, 1'b0);
    idle(3);

    // MUL leaves acc untouched; following MAC continues from 38
    send(2'b00, 32'h7FFF_FFFF, 32'd2, 1'b0);
    send(2'b01, 32'd1, 32'd1, 1'b0);
    idle(3);

    // SIMD dot product: (-1*2) + (3*5)
    send(2'b10, 32'h0003_FFFF, 32'h0005_0002, 1'b1);
    idle(3);

    // Saturating MAC at both rails
    send(2'b11, 32'h4000_0000, 32'd2, 1'b1);
    send(2'b11, 32'h4000_0000, 32'd2, 1'b0);
    send(2'b11, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    send(2'b11, 32'h8000_0000, 32'd1, 1'b1);
    send(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0);
    idle(3);

    // Backpressure: consumer stalls for 3 cycles after the first result
    send(2'b01, 32'd1, 32'd1, 1'b1);
    send(2'b01, 32'd2, 32'd2, 1'b0);
    res_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join_none
    send(2'b01, 32'd3, 32'd3, 1'b0);
    send(2'b01, 32'd4, 32'd4, 1'b0);
    idle(4);
    check("bp_all_delivered", 32'(sb_q.size()), 32'd0);

    // Mode change while an op is in flight
    send(2'b01, 32'd6, 32'd7, 1'b1);
    send(2'b00, 32'd9, 32'd9, 1'b0);
    send(2'b01, 32'd1, 32'd1, 1'b0);
    idle(3);

    // Reset while busy discards in-flight ops and the accumulator
    send(2'b01, 32'd10, 32'd10, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    m_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_no_emit", 32'(res_valid), 32'd0);
    send(2'b01, 32'd2, 32'd2, 1'b0);
    idle(4);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_mac_unit.md
Name: dsp_mac_unit

Overview:
- Execute-stage DSP multiply/accumulate unit. It consumes the 2-bit `dsp_mode` produced by the CSR file (CSR 0x800) and performs signed multiply, MAC, dual-16-bit SIMD dot-product or saturating MAC on operands from the integer pipeline.
- It is a 2-stage valid/ready pipeline with a persistent accumulator.
- Results return to writeback through a valid/ready handshake.

Parameters:
- ACC_W, 64: accumulator width in bits. Must be ≥ 64. Products are sign-extended to ACC_W.
- SAT_EN, 1: 1 enables saturation in mode 11; 0 makes mode 11 behave as mode 01.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- dsp_mode  input  2  operating mode from CSR file. 00 MUL, 01 MAC, 10 SIMD2x16 MAC, 11 saturating MAC.
- op_valid  input  1  operand pair valid.
- op_ready  output  1  unit can accept an operand pair this cycle.
- op_a  input  32  operand A, signed.
- op_b  input  32  operand B, signed.
- op_clr  input  1  with op: treat accumulator as 0 before this op's accumulate.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  32  result low word.
- res_hi  output  32  accumulator bits [63:32] after the op (modes 01/10). 0 in mode 00. Sign of saturated value in mode 11.
- busy  output  1  any op in flight (s1_valid | s2_valid).

Behaviour:
- Reset (async on rst_n low):
  - s1_valid = 0, s2_valid = 0, acc = 0.
  - res_data = 0, res_hi = 0.
  - Outputs: res_valid = 0, busy = 0, op_ready = 1.
- Handshakes:
  - Pipeline advance: `adv = !s2_valid | res_ready`.
  - `op_ready = adv`.
  - Op accepted on a clock edge with `op_valid & op_ready`.
  - res_valid holds with stable res_data/res_hi until res_ready.
- Stage 1, on adv:
  - Registers s1_valid = op_valid.
  - Registers mode = dsp_mode sampled at acceptance, plus clr = op_clr.
  - Registers product p:
    - Modes 00/01/11: p = sext(op_a * op_b), full 64-bit signed product.
    - Mode 10: p = sext(a[15:0]*b[15:0]) + sext(a[31:16]*b[31:16]), 16-bit signed halves, 33-bit sum.
- Stage 2, on adv with s1_valid:
  - base = clr ? 0 : acc.
  - 00: res_data = p[31:0], res_hi = 0, acc unchanged (clr ignored).
  - 01/10: acc_n = base + p mod 2^ACC_W. acc <= acc_n. res_data = acc_n[31:0], res_hi = acc_n[63:32].
  - 11 (SAT_EN = 1): s = base + p computed without overflow. acc_n = clamp(s, -2^31, 2^31-1). acc <= acc_n. res_data = acc_n[31:0]. res_hi = sign-extension.
  - s2_valid <= s1_valid. If s1_valid = 0 and adv, s2_valid <= 0.
- Latency:
  - Op accepted at edge N gives res_valid high after edge N+1 (2 edges to the result register).
  - Throughput is 1 op/cycle when res_ready is held high.
- Stall:
  - res_valid & !res_ready freezes s1, s2, acc and op_ready = 0.
  - No op is lost or duplicated.
- Ordering and mode changes:
  - Ops accumulate strictly in acceptance order.
  - A dsp_mode change affects only ops accepted afterwards; in-flight ops keep their latched mode.
- Accumulator:
  - Mixing modes shares one acc.
  - Mode 00 neither reads nor writes it.
- Wrap: modes 01/10 wrap silently at ACC_W bits, with no flag.
- Reset mid-operation: in-flight ops and acc are discarded, and nothing is emitted after rst_n rises.
- Concurrency: result consumption and new acceptance happen in the same cycle when s2_valid & res_ready.

Test Plan:
- Reset then mode 01, ops (3,4) clr=1, (5,-6), (7,8), res_ready=1 → results 12, -18, 38 on consecutive cycles, first res_valid 2 edges after first accept, res_hi = 0, -1, 0.
- Mode 00, (0x7FFFFFFF, 2) → res_data = 0xFFFFFFFE, res_hi = 0. A following mode 01 op (1,1) without clr → 39 (acc preserved from the previous scenario).
- Mode 10, clr=1, a = 0x0003FFFF (hi 3, lo -1), b = 0x00050002 (hi 5, lo 2) → p = -2 + 15 = 13, res_data = 13.
- Mode 11, clr=1, (0x40000000, 2) then (0x40000000, 2) → results 0x7FFFFFFF, 0x7FFFFFFF. Then (-1, 0x7FFFFFFF) → 0. Then clr (0x80000000, 1), (-1, 1) → 0x80000000, 0x80000000.
- Backpressure: stream 4 mode-01 ops with res_ready low for 3 cycles after the first result → op_ready = 0 while stalled, res_data held, all 4 results delivered exactly once in order.
- Mode switch: accept op in mode 01, change dsp_mode to 00 the next cycle → in-flight op still accumulates. Also assert rst_n low while busy=1 → res_valid = 0 and acc = 0 immediately, and the next mode-01 op (2,2) without clr returns 4.
